// File: rtl/uart_tx.sv
// uart_tx: bus-attached 8N1 UART transmitter with a byte FIFO, status register and end-of-frame pulse
module uart_tx #(
  parameter int SYS_CLK    = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int TICK       = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_dat,
  output logic [7:0] o_dat,
  input  logic       i_addr,
  input  logic       i_we,
  input  logic       i_cyc,
  output logic       tx,
  output logic       o_int
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
  if (TICK < 2 || TICK > 512 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BAUDRATE > SYS_CLK) begin : g_bad_cfg
    $error("uart_tx: bad parameters");
  end
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic [1:0] state_q, state_d;
  logic [8:0] baud_q, baud_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] idx_q, idx_d;
  logic tx_q, tx_d, int_q, int_d, ov_q;
  logic full, empty, tick, push_req, push, pop, rd_stat;
  logic [7:0] head;
  assign full     = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty    = cnt_q == '0;
  assign tick     = baud_q == 9'(TICK - 1);
  assign push_req = i_cyc & i_we & ~i_addr;
  assign push     = push_req & ~full;
  assign pop      = ~empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & tick));
  assign rd_stat  = i_cyc & ~i_we & i_addr;
  assign head     = mem_q[rp_q];
  assign o_dat    = i_addr ? {4'd0, ov_q, empty, full, state_q != S_IDLE} : 8'd0;
  assign tx       = tx_q;
  assign o_int    = int_q;
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 9'd1;
    sh_d    = sh_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    int_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d  = '0;
        state_d = pop ? S_START : S_IDLE;
        sh_d    = pop ? head : sh_q;
        tx_d    = ~pop;
      end
      S_START: if (tick) begin
        baud_d  = '0;
        state_d = S_DATA;
        tx_d    = sh_q[0];
        idx_d   = '0;
      end
      S_DATA: if (tick) begin
        baud_d  = '0;
        state_d = (idx_q == 3'd7) ? S_STOP : S_DATA;
        tx_d    = (idx_q == 3'd7) ? 1'b1 : sh_q[1];
        sh_d    = sh_q >> 1;
        idx_d   = idx_q + 3'd1;
      end
      default: if (tick) begin
        baud_d  = '0;
        int_d   = 1'b1;
        state_d = pop ? S_START : S_IDLE;
        sh_d    = pop ? head : sh_q;
        tx_d    = ~pop;
      end
    endcase
  end
  always_ff @(posedge i_clk)
    if (push) mem_q[wp_q] <= i_dat;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      int_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      int_q   <= int_d;
      wp_q    <= push ? wp_q + AW'(1) : wp_q;
      rp_q    <= pop ? rp_q + AW'(1) : rp_q;
      cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      ov_q    <= (push_req & full) | (ov_q & ~rd_stat);
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx
module tb_uart_tx;
  localparam int T = 434;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] dat = 8'd0;
  logic addr = 1'b0, we = 1'b0, cyc = 1'b0;
  logic [7:0] o_dat;
  logic tx, o_int;
  always #5 clk = ~clk;
  uart_tx #(.TICK(T), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_dat(dat), .o_dat(o_dat), .i_addr(addr),
    .i_we(we), .i_cyc(cyc), .tx(tx), .o_int(o_int)
  );
  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  int ncyc = 0, rc = 0, ferr = 0;
  logic prev_tx = 1'b1, rbusy = 1'b0;
  logic [9:0] rsh = '0;
  int falls[$], ints[$];
  logic [7:0] rx[$];
  always @(negedge clk) begin
    ncyc++;
    if (o_int) ints.push_back(ncyc);
    if (rst) rbusy = 1'b0;
    else if (rbusy) begin
      rc++;
      if (rc % T == T / 2) begin
        rsh = {tx, rsh[9:1]};
        if (rc / T == 9) begin
          rbusy = 1'b0;
          if (rsh[0] !== 1'b0 || rsh[9] !== 1'b1) ferr++;
          rx.push_back(rsh[8:1]);
        end
      end
    end else if (prev_tx && !tx) begin
      rbusy = 1'b1;
      rc = 0;
      falls.push_back(ncyc);
    end
    prev_tx = tx;
  end
  task automatic clear_mon();
    falls.delete();
    ints.delete();
    rx.delete();
    ferr = 0;
  endtask
  task automatic wr(input logic [7:0] d);
    cyc = 1'b1; we = 1'b1; addr = 1'b0; dat = d;
    @(posedge clk);
    #1;
    cyc = 1'b0; we = 1'b0;
  endtask
  task automatic rd_status(input string nm, input logic [7:0] exp);
    addr = 1'b1; we = 1'b0;
    #1;
    chk(nm, o_dat, exp);
    addr = 1'b0;
  endtask
  task automatic wait_frames(input string nm, input int n, input int budget);
    int c = 0;
    while ((rx.size() < n || ints.size() < n) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(nm, (rx.size() >= n && ints.size() >= n), 1);
  endtask
  typedef struct {
    string      name;
    logic [7:0] dat;
    logic [9:0] line;
  } vec_t;
  vec_t vt[3];
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0] = '{"x55", 8'h55, 10'b1010101010};
    vt[1] = '{"x0F", 8'h0F, 10'b1000011110};
    vt[2] = '{"x80", 8'h80, 10'b1100000000};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset o_int", o_int, 0);
    rd_status("reset status", 8'h04);
    addr = 1'b0;
    #1 chk("data reg reads 0", o_dat, 0);
    foreach (vt[i]) begin
      int errs[10];
      int ip;
      errs = '{default: 0};
      ip = 0;
      clear_mon();
      wr(vt[i].dat);
      @(negedge clk);
      chk({vt[i].name, " latency"}, tx, 1);
      for (int k = 0; k < 10 * T; k++) begin
        @(negedge clk);
        if (tx !== vt[i].line[k / T]) errs[k / T]++;
        if (o_int) ip++;
      end
      for (int b = 0; b < 10; b++) chk($sformatf("%s bit%0d bad cycles", vt[i].name, b), errs[b], 0);
      chk({vt[i].name, " o_int early"}, ip, 0);
      @(negedge clk);
      chk({vt[i].name, " o_int pulse"}, o_int, 1);
      chk({vt[i].name, " tx idle"}, tx, 1);
      @(negedge clk);
      chk({vt[i].name, " o_int one cycle"}, o_int, 0);
      rd_status({vt[i].name, " status after"}, 8'h04);
      chk({vt[i].name, " rx count"}, rx.size(), 1);
      if (rx.size() == 1) chk({vt[i].name, " rx byte"}, rx[0], vt[i].dat);
    end
    clear_mon();
    for (int i = 1; i <= 6; i++) wr(8'(i));
    rd_status("six writes status", 8'h0B);
    addr = 1'b1; we = 1'b0; cyc = 1'b0;
    @(posedge clk);
    #1;
    rd_status("ov kept without cyc", 8'h0B);
    addr = 1'b1; we = 1'b0; cyc = 1'b1;
    @(posedge clk);
    #1 cyc = 1'b0;
    rd_status("ov cleared by read", 8'h03);
    wait_frames("five frames", 5, 5 * 10 * T + 100);
    for (int i = 0; i < 5 && i < rx.size(); i++) chk($sformatf("burst byte%0d", i), rx[i], 8'(i + 1));
    for (int i = 0; i + 1 < falls.size() && i < 4; i++) chk($sformatf("burst gap%0d", i), falls[i + 1] - falls[i], 10 * T);
    if (ints.size() >= 5 && falls.size() >= 1) chk("burst span", ints[4] - falls[0], 5 * 10 * T);
    repeat (10 * T + 100) @(negedge clk);
    chk("burst frames total", rx.size(), 5);
    chk("burst o_int total", ints.size(), 5);
    chk("burst framing", ferr, 0);
    rd_status("burst status after", 8'h04);
    clear_mon();
    wr(8'hA5);
    wr(8'h11);
    wr(8'h22);
    repeat (1100) @(negedge clk);
    chk("a5 data bit1 low", tx, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid reset tx", tx, 1);
    chk("mid reset o_int", o_int, 0);
    rd_status("mid reset status", 8'h04);
    begin
      int nf, ni;
      nf = falls.size();
      ni = ints.size();
      repeat (3 * 10 * T) @(negedge clk);
      chk("no frames after reset", falls.size(), nf);
      chk("no o_int after reset", ints.size(), ni);
    end
    clear_mon();
    wr(8'hFF);
    wr(8'h00);
    wait_frames("ff00 frames", 2, 2 * 10 * T + 100);
    if (rx.size() >= 2) begin
      chk("ff00 first byte", rx[0], 8'hFF);
      chk("ff00 second byte", rx[1], 8'h00);
    end
    chk("ff00 framing", ferr, 0);
    if (falls.size() >= 2) chk("ff00 no gap", falls[1] - falls[0], 10 * T);
    if (ints.size() >= 2 && falls.size() >= 1) chk("ff00 span", ints[1] - falls[0], 20 * T);
    repeat (20) @(negedge clk);
    chk("ff00 o_int total", ints.size(), 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
